// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between the instruction-fetch requester (i_*)
// and the load/store requester (d_*). Only one transaction is in flight at a time.
// When both requesters are high in the same cycle, the one that did not own the
// previous transaction wins (round-robin).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   i_req/i_addr     fetch request in; i_gnt / i_rvalid / i_rdata back
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request in; d_gnt / d_rvalid / d_rdata back
//   m_req/m_we/m_be/m_addr/m_wdata  memory request out; m_gnt / m_rvalid / m_rdata in
//   busy             a transaction is in flight
//   owner            0 = fetch, 1 = data (holds its value while idle)
//   err              sticky flag for a memory response that arrives outside WAIT
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    logic              w_gnt_i;
    logic              w_gnt_d;

    // Grant decode: only in IDLE; on a tie the requester that did not go last wins.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_req && d_req) begin
                w_gnt_d = ~r_last_owner;
                w_gnt_i = r_last_owner;
            end else begin
                w_gnt_i = i_req;
                w_gnt_d = d_req;
            end
        end else begin
            w_gnt_i = 1'b0;
            w_gnt_d = 1'b0;
        end
    end

    // Transaction sequencer, request register, response routing and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= {BE_W{1'b0}};
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_i_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_i_rdata    <= {DATA_W{1'b0}};
            r_d_rdata    <= {DATA_W{1'b0}};
            r_err        <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A response with nothing outstanding is dropped and flagged.
                    if (m_rvalid) begin
                        r_err <= 1'b1;
                    end
                    if (w_gnt_i) begin
                        r_addr       <= i_addr;
                        r_we         <= 1'b0;
                        r_be         <= {BE_W{1'b1}};
                        r_wdata      <= {DATA_W{1'b0}};
                        r_owner      <= 1'b0;
                        r_last_owner <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end else if (w_gnt_d) begin
                        r_addr       <= d_addr;
                        r_we         <= d_we;
                        r_be         <= d_be;
                        r_wdata      <= d_wdata;
                        r_owner      <= 1'b1;
                        r_last_owner <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The request is not yet accepted, so a response here is bogus;
                    // an accompanying m_gnt is still honoured.
                    if (m_rvalid) begin
                        r_err <= 1'b1;
                    end
                    if (m_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        if (r_owner) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_we ? {DATA_W{1'b0}} : m_rdata;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= r_we ? {DATA_W{1'b0}} : m_rdata;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_req    = (r_state == ST_ISSUE);
    assign m_we     = r_we;
    assign m_be     = r_be;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign busy     = (r_state != ST_IDLE);
    assign owner    = r_owner;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level reference model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        busy, owner, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .owner(owner), .err(err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          mem_rand = 1'b0;
    int          rdly     = 0;
    int          stall    = 0;
    bit          spur     = 1'b0;
    logic [31:0] mem_data = 32'h0;

    initial begin : responder
        bit c_acc, c_resp, c_rst, pend;
        int dly;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        pend = 1'b0; dly = 0;
        forever begin
            @(negedge clk);
            c_acc  = (m_req === 1'b1) && (m_gnt === 1'b1);
            c_resp = (m_rvalid === 1'b1);
            c_rst  = rst;
            @(posedge clk);
            #2;
            m_rvalid = 1'b0;
            if (c_rst) begin
                pend = 1'b0;
            end else begin
                if (c_resp) pend = 1'b0;
                if (c_acc) begin
                    pend = 1'b1;
                    dly  = mem_rand ? int'($urandom_range(0, 3)) : rdly;
                end
            end
            if (spur) begin
                m_rvalid = 1'b1;
                spur     = 1'b0;
            end else if (pend) begin
                if (dly == 0) m_rvalid = 1'b1;
                else dly--;
            end
            m_rdata = mem_rand ? $urandom : mem_data;
            if (m_req === 1'b1) begin
                if (stall > 0) begin
                    m_gnt = 1'b0;
                    stall--;
                end else begin
                    m_gnt = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                m_gnt = 1'b0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          md_ok = 1'b0;
    bit          t_valid, t_sent, t_owner, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata;
    bit          mo_owner, mo_last, mo_err, e_irv, e_drv;
    logic [31:0] e_ird, e_drd;

    always @(negedge clk) begin
        bit gi, gd, was_wait;
        gi = 1'b0; gd = 1'b0;
        if (!t_valid) begin
            if (i_req && d_req) begin
                gd = !mo_last;
                gi = mo_last;
            end else begin
                gi = i_req;
                gd = d_req;
            end
        end
        if (md_ok) begin
            chk("i_gnt", 32'(i_gnt), 32'(gi));
            chk("d_gnt", 32'(d_gnt), 32'(gd));
            chk("busy", 32'(busy), 32'(t_valid));
            chk("owner", 32'(owner), 32'(mo_owner));
            chk("m_req", 32'(m_req), 32'(t_valid && !t_sent));
            if (t_valid && !t_sent) begin
                chk("m_addr", m_addr, t_addr);
                chk("m_we", 32'(m_we), 32'(t_we));
                chk("m_be", 32'(m_be), 32'(t_be));
                chk("m_wdata", m_wdata, t_wdata);
            end
            chk("err", 32'(err), 32'(mo_err));
            chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("i_rdata", i_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);
        end
        if (rst) begin
            t_valid = 1'b0; t_sent = 1'b0; t_owner = 1'b0; t_we = 1'b0;
            t_be = 4'h0; t_addr = 32'h0; t_wdata = 32'h0;
            mo_owner = 1'b0; mo_last = 1'b0; mo_err = 1'b0;
            e_irv = 1'b0; e_drv = 1'b0; e_ird = 32'h0; e_drd = 32'h0;
            md_ok = 1'b1;
        end else if (md_ok) begin
            e_irv = 1'b0; e_drv = 1'b0;
            was_wait = t_valid && t_sent;
            if (m_rvalid) begin
                if (was_wait) begin
                    if (t_owner) begin e_drv = 1'b1; e_drd = t_we ? 32'h0 : m_rdata; end
                    else begin e_irv = 1'b1; e_ird = t_we ? 32'h0 : m_rdata; end
                    t_valid = 1'b0;
                end else begin
                    mo_err = 1'b1;
                end
            end
            if (t_valid && !was_wait && m_gnt) t_sent = 1'b1;
            if (gi || gd) begin
                t_valid = 1'b1; t_sent = 1'b0; t_owner = gd;
                mo_owner = gd; mo_last = gd;
                t_addr  = gd ? d_addr : i_addr;
                t_we    = gd ? d_we : 1'b0;
                t_be    = gd ? d_be : 4'hf;
                t_wdata = gd ? d_wdata : 32'h0;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : main
        int  ng;
        bit  order [4];
        bit  fetch_next, seen, cg_i, cg_d;

        // Reset, then a single load.
        do_reset();
        sample();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_m_req", 32'(m_req), 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        step();
        mem_data = 32'hDEADBEEF; rdly = 0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h100;
        sample(); chk("load_d_gnt_c0", 32'(d_gnt), 32'h1);
        step(); d_req = 1'b0;
        sample();
        chk("load_m_req_c1", 32'(m_req), 32'h1);
        chk("load_m_addr_c1", m_addr, 32'h100);
        chk("load_m_we_c1", 32'(m_we), 32'h0);
        step(); sample(); chk("load_d_rvalid_c2", 32'(d_rvalid), 32'h0);
        step(); sample();
        chk("load_d_rvalid_c3", 32'(d_rvalid), 32'h1);
        chk("load_d_rdata_c3", d_rdata, 32'hDEADBEEF);
        chk("load_i_rvalid_c3", 32'(i_rvalid), 32'h0);

        // Tie after reset: data, fetch, data, fetch.
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h300; d_wdata = 32'h55;
        ng = 0; fetch_next = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (fetch_next) begin
                chk("tie_fetch_m_be", 32'(m_be), 32'(4'hf));
                chk("tie_fetch_m_we", 32'(m_we), 32'h0);
                fetch_next = 1'b0;
            end
            if ((i_gnt || d_gnt) && ng < 4) begin
                order[ng] = d_gnt;
                ng++;
                fetch_next = i_gnt;
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("tie_count", 32'(ng), 32'd4);
        chk("tie_0_data", 32'(order[0]), 32'h1);
        chk("tie_1_fetch", 32'(order[1]), 32'h0);
        chk("tie_2_data", 32'(order[2]), 32'h1);
        chk("tie_3_fetch", 32'(order[3]), 32'h0);
        repeat (6) step();

        // Store with 4 cycles of backpressure.
        stall = 4;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h400; d_wdata = 32'h12345678;
        sample(); chk("store_d_gnt", 32'(d_gnt), 32'h1);
        step(); d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("store_m_req", 32'(m_req), 32'h1);
            chk("store_m_wdata", m_wdata, 32'h12345678);
            chk("store_m_be", 32'(m_be), 32'h3);
            chk("store_m_we", 32'(m_we), 32'h1);
            chk("store_busy", 32'(busy), 32'h1);
            step();
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            sample();
            if (d_rvalid) begin
                chk("store_d_rdata", d_rdata, 32'h0);
                seen = 1'b1;
            end else begin
                chk("store_busy_wait", 32'(busy), 32'h1);
            end
            step();
        end
        chk("store_completed", 32'(seen), 32'h1);
        repeat (2) step();

        // Fetch arriving while a load waits in WAIT.
        rdly = 2; mem_data = 32'hA5A50001;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h500;
        sample(); chk("busyreq_d_gnt", 32'(d_gnt), 32'h1);
        step(); d_req = 1'b0;
        step(); i_req = 1'b1; i_addr = 32'h600;
        for (int k = 2; k < 5; k++) begin
            sample(); chk("busyreq_no_i_gnt", 32'(i_gnt), 32'h0);
            step();
        end
        sample();
        chk("busyreq_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("busyreq_i_gnt", 32'(i_gnt), 32'h1);
        step(); i_req = 1'b0; rdly = 0;
        repeat (5) step();

        // Spurious response in IDLE.
        spur = 1'b1;
        sample(); chk("spur_err_before", 32'(err), 32'h0);
        step(); sample();
        chk("spur_err", 32'(err), 32'h1);
        chk("spur_no_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("spur_no_d_rvalid", 32'(d_rvalid), 32'h0);
        step();
        i_req = 1'b1; i_addr = 32'h700; mem_data = 32'h0BADF00D;
        sample(); chk("spur_fetch_gnt", 32'(i_gnt), 32'h1);
        step(); i_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            sample();
            if (i_rvalid) begin
                chk("spur_fetch_rdata", i_rdata, 32'h0BADF00D);
                seen = 1'b1;
            end
            step();
        end
        chk("spur_fetch_done", 32'(seen), 32'h1);
        sample(); chk("spur_err_sticky", 32'(err), 32'h1);
        step();

        // Reset while waiting for a response.
        rdly = 3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
        step(); d_req = 1'b0;
        step(); rst = 1'b1;
        sample(); chk("rstmid_busy_before", 32'(busy), 32'h1);
        step(); rst = 1'b0; rdly = 0;
        sample();
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_m_req", 32'(m_req), 32'h0);
        chk("rstmid_err", 32'(err), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(); sample();
            chk("rstmid_no_d_rvalid", 32'(d_rvalid), 32'h0);
        end
        step();
        mem_data = 32'hCAFE0000;
        i_req = 1'b1; i_addr = 32'h0;
        sample(); chk("rstmid_fetch_gnt", 32'(i_gnt), 32'h1);
        step(); i_req = 1'b0;
        step(); step(); sample();
        chk("rstmid_fetch_rvalid_c3", 32'(i_rvalid), 32'h1);
        chk("rstmid_fetch_rdata", i_rdata, 32'hCAFE0000);
        step();

        // Randomized traffic with a randomly behaving memory.
        mem_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            sample();
            cg_i = i_gnt; cg_d = d_gnt;
            step();
            if (cg_i) i_req = 1'b0;
            if (cg_d) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (20) step();
        mem_rand = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
